// File: rtl/digimod_pkg.sv
// Shared definitions for the digital demodulator: mode encodings, FSM states
// and the accumulator width helper.
package digimod_pkg;

  localparam logic [1:0] MOD_ASK  = 2'd0;
  localparam logic [1:0] MOD_BPSK = 2'd1;
  localparam logic [1:0] MOD_BFSK = 2'd2;
  localparam logic [1:0] MOD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    DECIDE = 2'd2
  } demodState_t;

  // Headroom for SPS full-scale samples plus one bit so |A| never wraps.
  function automatic int accW(input int sampleW, input int sps);
    return sampleW + $clog2(sps) + 1;
  endfunction

endpackage

// File: rtl/digital_demod_if.sv
// Sample, mode and bit-read signals of the demodulator; the sample source and
// bit sink use the master modport, the demodulator the slave modport.
interface digital_demod_if #(
  parameter int SAMPLE_W = 16
);
  logic [1:0]                 SELMod;
  logic signed [SAMPLE_W-1:0] sIn;
  logic                       sValid;
  logic                       rEN;
  logic                       dOut;
  logic                       dValid;
  logic                       bEmpty;
  logic                       bFull;
  logic                       bOvf;

  modport master (
    output SELMod, sIn, sValid, rEN,
    input  dOut, dValid, bEmpty, bFull, bOvf
  );

  modport slave (
    input  SELMod, sIn, sValid, rEN,
    output dOut, dValid, bEmpty, bFull, bOvf
  );
endinterface

// File: rtl/digital_demod_bit_fifo.sv
// 1-bit synchronous FIFO with registered read data/strobe and sticky overflow.
// A write into a full FIFO succeeds when a read is accepted on the same edge.
module bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic wrEn,
  input  logic wrBit,
  input  logic rdEn,
  output logic dOut,
  output logic dValid,
  output logic empty,
  output logic full,
  output logic ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wPtr, rPtr, wPtrNext, rPtrNext;
  logic             rdOk, wrOk;

  always_comb begin
    rdOk     = rdEn && !empty;
    wrOk     = wrEn && (!full || rdOk);
    wPtrNext = wPtr + {{AW{1'b0}}, wrOk};
    rPtrNext = rPtr + {{AW{1'b0}}, rdOk};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem    <= '0;
      wPtr   <= '0;
      rPtr   <= '0;
      dOut   <= 1'b0;
      dValid <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      wPtr   <= wPtrNext;
      rPtr   <= rPtrNext;
      dValid <= rdOk;
      if (wrOk)
        mem[wPtr[AW-1:0]] <= wrBit;
      if (rdOk)
        dOut <= mem[rPtr[AW-1:0]];
      // Flags track the pointers as they will be after this edge.
      empty <= (wPtrNext == rPtrNext);
      full  <= (wPtrNext == {~rPtrNext[AW], rPtrNext[AW-1:0]});
      if (wrEn && full && !rdOk)
        ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/digital_demod.sv
// Symbol-rate correlating demodulator (ASK / BPSK / BFSK) feeding a bit FIFO.
// BFSK and its A2/f2 path exist only when DIGIMOD_FSK_EN is defined.
//
// state  | meaning
// IDLE   | no sample seen since reset
// ACQ    | accumulating the current symbol
// DECIDE | one cycle: push decided bit; a sample here is phase 0 of next symbol
module digital_demod
  import digimod_pkg::*;
#(
  parameter int SPS      = 16,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 8,
  parameter int ASK_TH   = 4096
) (
  input logic             CLK,
  input logic             RESET,
  digital_demod_if.slave  bus
);
  localparam int ACC_W = accW(SAMPLE_W, SPS);
  localparam int PW    = $clog2(SPS);
  localparam logic [PW-1:0] LAST_PH = PW'(SPS - 1);

  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t ASK_THR = acc_t'(ASK_TH);

  demodState_t state, stateNext;

  logic [PW-1:0]              phase, phReg;
  logic signed [SAMPLE_W-1:0] sReg;
  logic                       vReg;
  logic [1:0]                 modeReg;
  acc_t                       a1, a1Next, term1, sExt, negS;
  logic                       bitNext, modeWr, pendBit, pendWr;
  logic                       accEn, symEnd, fifoWr;
`ifdef DIGIMOD_FSK_EN
  acc_t                       a2, a2Next, term2;
  logic [ACC_W-1:0]           absA1, absA2;
`endif

  // Sample capture stage; the mode is frozen with the phase-0 sample.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase   <= '0;
      phReg   <= '0;
      sReg    <= '0;
      vReg    <= 1'b0;
      modeReg <= MOD_ASK;
    end else begin
      vReg <= bus.sValid;
      if (bus.sValid) begin
        sReg  <= bus.sIn;
        phReg <= phase;
        phase <= phase + PW'(1);
        if (phase == '0)
          modeReg <= bus.SELMod;
      end
    end
  end

  always_comb begin
    sExt    = acc_t'(sReg);
    negS    = -sExt;
    term1   = '0;
    modeWr  = 1'b0;
    case (modeReg)
      MOD_ASK: begin
        term1  = sReg[SAMPLE_W-1] ? negS : sExt;
        modeWr = 1'b1;
      end
      MOD_BPSK: begin
        term1  = phReg[PW-1] ? negS : sExt;
        modeWr = 1'b1;
      end
`ifdef DIGIMOD_FSK_EN
      MOD_BFSK: begin
        term1  = phReg[PW-1] ? negS : sExt;
        modeWr = 1'b1;
      end
`endif
      default: ;
    endcase
    a1Next = a1 + term1;
`ifdef DIGIMOD_FSK_EN
    term2  = (modeReg == MOD_BFSK) ? (phReg[PW-2] ? negS : sExt) : '0;
    a2Next = a2 + term2;
    absA1  = a1Next[ACC_W-1] ? -a1Next : a1Next;
    absA2  = a2Next[ACC_W-1] ? -a2Next : a2Next;
`endif
    bitNext = 1'b0;
    case (modeReg)
      MOD_ASK:  bitNext = (a1Next >= ASK_THR);
      MOD_BPSK: bitNext = !a1Next[ACC_W-1];
`ifdef DIGIMOD_FSK_EN
      MOD_BFSK: bitNext = (absA2 > absA1);
`endif
      default:  bitNext = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accEn     = 1'b0;
    symEnd    = 1'b0;
    fifoWr    = 1'b0;
    case (state)
      IDLE: begin
        if (vReg) begin
          accEn     = 1'b1;
          stateNext = ACQ;
        end
      end
      ACQ: begin
        if (vReg) begin
          accEn = 1'b1;
          if (phReg == LAST_PH) begin
            symEnd    = 1'b1;
            stateNext = DECIDE;
          end
        end
      end
      DECIDE: begin
        fifoWr    = pendWr;
        accEn     = vReg;
        stateNext = ACQ;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a1      <= '0;
      pendBit <= 1'b0;
      pendWr  <= 1'b0;
    end else if (symEnd) begin
      a1      <= '0;
      pendBit <= bitNext;
      pendWr  <= modeWr;
    end else if (accEn) begin
      a1 <= a1Next;
    end
  end

`ifdef DIGIMOD_FSK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      a2 <= '0;
    else if (symEnd)
      a2 <= '0;
    else if (accEn)
      a2 <= a2Next;
  end
`endif

  bit_fifo #(.DEPTH(DEPTH)) uFifo (
    .CLK    (CLK),
    .RESET  (RESET),
    .wrEn   (fifoWr),
    .wrBit  (pendBit),
    .rdEn   (bus.rEN),
    .dOut   (bus.dOut),
    .dValid (bus.dValid),
    .empty  (bus.bEmpty),
    .full   (bus.bFull),
    .ovf    (bus.bOvf)
  );
endmodule
